// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction-fetch stage: FSM states, jump-select
// encodings and the instruction word width.
package fetch_unit_pkg;

    localparam int INS_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [1:0] JMP_NONE = 2'b00;
    localparam logic [1:0] JMP_REL  = 2'b01;
    localparam logic [1:0] JMP_ABS  = 2'b10;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: absolute jump, PC-relative
// (jump or taken branch) or sequential. All sums wrap modulo 2^PC_W.
module next_pc_calc #(
    parameter int PC_W = 8
) (
    input  logic [PC_W-1:0] pc,
    input  logic            branch,
    input  logic [1:0]      jump,
    input  logic [7:0]      imm,
    input  logic [PC_W-1:0] rega,
    output logic [PC_W-1:0] next_pc,
    output logic [PC_W-1:0] pc_plus1
);

    logic [PC_W-1:0] imm_ext;

    assign imm_ext  = PC_W'($signed(imm));
    assign pc_plus1 = pc + PC_W'(1);

    // Bit 1 wins, so Jump=11 behaves as an absolute jump.
    always_comb begin
        next_pc = pc_plus1;
        if (jump[1])
            next_pc = rega;
        else if (jump[0] || branch)
            next_pc = pc + imm_ext;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one instruction per
// controller step over a req/ack port, and stops on halt or ack timeout.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int PC_W        = 8,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             Rst,
    input  logic             Buff_PC,
    input  logic             Branch,
    input  logic [1:0]       Jump,
    input  logic             Done,
    input  logic [7:0]       Imm,
    input  logic [PC_W-1:0]  RegA,
    output logic             mem_req,
    output logic [PC_W-1:0]  mem_addr,
    input  logic             mem_ack,
    input  logic [INS_W-1:0] mem_rdata,
    output logic [INS_W-1:0] Ins,
    output logic             InsValid,
    output logic [PC_W-1:0]  PC,
    output logic [PC_W-1:0]  PCplus1,
    output logic             Halted,
    output logic             FetchErr
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] to_cnt;
    logic [PC_W-1:0]  next_pc;
    logic             load_ins, commit_pc, set_halt, set_err, cnt_clr, cnt_inc;

    next_pc_calc #(.PC_W(PC_W)) u_next_pc (
        .pc       (PC),
        .branch   (Branch),
        .jump     (Jump),
        .imm      (Imm),
        .rega     (RegA),
        .next_pc  (next_pc),
        .pc_plus1 (PCplus1)
    );

    always_ff @(posedge clk) begin
        if (!Rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        load_ins  = 1'b0;
        commit_pc = 1'b0;
        set_halt  = 1'b0;
        set_err   = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            IDLE: begin
                state_nx = FETCH;
                cnt_clr  = 1'b1;
            end
            FETCH: begin
                // to_cnt counts ack-less FETCH cycles already spent
                if (mem_ack) begin
                    load_ins = 1'b1;
                    state_nx = EXEC;
                end else if (to_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                    set_err  = 1'b1;
                    set_halt = 1'b1;
                    state_nx = HALT;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            EXEC: begin
                if (Buff_PC) begin
                    commit_pc = 1'b1;
                    cnt_clr   = 1'b1;
                end
                // Done takes the state even when the PC is committed too
                if (Done) begin
                    set_halt = 1'b1;
                    state_nx = HALT;
                end else if (Buff_PC) begin
                    state_nx = FETCH;
                end
            end
            HALT:    state_nx = HALT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!Rst) begin
            PC       <= '0;
            Ins      <= '0;
            InsValid <= 1'b0;
            Halted   <= 1'b0;
            FetchErr <= 1'b0;
            to_cnt   <= '0;
        end else begin
            if (load_ins) begin
                Ins      <= mem_rdata;
                InsValid <= 1'b1;
            end
            if (commit_pc) begin
                PC       <= next_pc;
                InsValid <= 1'b0;
            end
            if (set_halt) Halted   <= 1'b1;
            if (set_err)  FetchErr <= 1'b1;
            if (cnt_clr)      to_cnt <= '0;
            else if (cnt_inc) to_cnt <= to_cnt + CNT_W'(1);
        end
    end

    assign mem_req  = (state == FETCH);
    assign mem_addr = PC;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: stimulus predicts fetch
// addresses/instructions, a monitor checks them as the DUT presents them.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int PC_W = 8;
    localparam int TO   = 15;

    logic            clk = 1'b0, Rst = 1'b0;
    logic            Buff_PC = 1'b0, Branch = 1'b0, Done = 1'b0;
    logic [1:0]      Jump = 2'b00;
    logic [7:0]      Imm = 8'h00;
    logic [PC_W-1:0] RegA = '0;
    logic            mem_ack = 1'b0;
    logic [15:0]     mem_rdata = 16'h0;
    logic            mem_req, InsValid, Halted, FetchErr;
    logic [PC_W-1:0] mem_addr, PC, PCplus1;
    logic [15:0]     Ins;

    fetch_unit #(.PC_W(PC_W), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .Rst(Rst), .Buff_PC(Buff_PC), .Branch(Branch), .Jump(Jump),
        .Done(Done), .Imm(Imm), .RegA(RegA), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .Ins(Ins), .InsValid(InsValid),
        .PC(PC), .PCplus1(PCplus1), .Halted(Halted), .FetchErr(FetchErr)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic [15:0]     mem [256];
    int              lat = 1;   // FETCH cycle in which memory acks; 0 = never
    int              fcyc = 0;
    logic [PC_W-1:0] exp_addr_q[$];
    logic [15:0]     exp_ins_q[$];
    logic [PC_W-1:0] model_pc = '0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Memory responder: acks on the chosen FETCH cycle, random junk otherwise.
    always @(negedge clk) begin
        if (mem_req) begin
            fcyc++;
            if (lat != 0 && fcyc == lat) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr];
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 16'($urandom);
            end
        end else begin
            fcyc      = 0;
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = 16'($urandom);
        end
    end

    // Monitor: compares each new request and each newly valid instruction.
    logic            prev_req = 1'b0, prev_vld = 1'b0;
    logic [15:0]     cur_ins = 16'h0, e_ins;
    logic [PC_W-1:0] e_addr, e_addr1;
    always @(posedge clk) begin
        #1;
        if (mem_req && !prev_req) begin
            if (exp_addr_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL fetch_req: unexpected request at addr %0h", mem_addr);
            end else begin
                e_addr  = exp_addr_q.pop_front();
                e_addr1 = e_addr + 1'b1;
                chk("fetch_addr", 32'(mem_addr), 32'(e_addr));
                chk("pc_plus1", 32'(PCplus1), 32'(e_addr1));
            end
        end
        if (InsValid && !prev_vld) begin
            if (exp_ins_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL ins_valid: unexpected instruction %0h", Ins);
            end else begin
                e_ins   = exp_ins_q.pop_front();
                cur_ins = e_ins;
                chk("ins", 32'(Ins), 32'(e_ins));
            end
        end else if (InsValid && prev_vld) begin
            chk("ins_hold", 32'(Ins), 32'(cur_ins));
        end
        prev_req = mem_req;
        prev_vld = InsValid;
    end

    task automatic do_reset(input int l);
        Rst = 1'b0; Buff_PC = 1'b0; Done = 1'b0; Branch = 1'b0; Jump = JMP_NONE;
        lat = l;
        @(negedge clk);
        chk("rst_pc", 32'(PC), 0);
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_insvalid", 32'(InsValid), 0);
        chk("rst_ins", 32'(Ins), 0);
        chk("rst_halted", 32'(Halted), 0);
        chk("rst_fetcherr", 32'(FetchErr), 0);
        chk("rst_pcplus1", 32'(PCplus1), 1);
        model_pc = '0;
        exp_addr_q.push_back('0);
        if (l != 0) exp_ins_q.push_back(mem[0]);
        Rst = 1'b1;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 40; i++) begin
            if (InsValid) return;
            @(negedge clk);
        end
        checks++; errors++;
        $display("FAIL wait_valid: InsValid got 0 expected 1 within 40 cycles");
    endtask

    task automatic issue(input logic b, input logic d, input logic br, input logic [1:0] j,
                         input logic [7:0] im, input logic [PC_W-1:0] ra, input int nl);
        logic [PC_W-1:0] npc;
        wait_valid();
        if (j[1])            npc = ra;
        else if (j[0] || br) npc = PC_W'(int'(model_pc) + int'($signed(im)));
        else                 npc = PC_W'(int'(model_pc) + 1);
        Buff_PC = b; Done = d; Branch = br; Jump = j; Imm = im; RegA = ra;
        lat = nl;
        if (b) begin
            model_pc = npc;
            if (!d) begin
                exp_addr_q.push_back(npc);
                if (nl != 0) exp_ins_q.push_back(mem[npc]);
            end
        end
        @(negedge clk);
        Buff_PC = 1'b0; Done = 1'b0; Branch = 1'b0; Jump = JMP_NONE;
        Imm = 8'($urandom); RegA = PC_W'($urandom);
        if (b) chk("pc_commit", 32'(PC), 32'(npc));
        if (d) begin
            chk("halt_flag", 32'(Halted), 1);
            chk("halt_req", 32'(mem_req), 0);
        end else if (b) begin
            chk("req_after_buff", 32'(mem_req), 1);
            chk("insvalid_clear", 32'(InsValid), 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[0] = 16'hA5C3;
        @(negedge clk);

        // Reset release, ack tied to the first FETCH cycle
        do_reset(1);
        @(negedge clk);
        chk("c1_req", 32'(mem_req), 1);
        chk("c1_addr", 32'(mem_addr), 0);
        @(negedge clk);
        chk("c2_ins", 32'(Ins), 32'h A5C3);
        chk("c2_valid", 32'(InsValid), 1);

        // Directed next-PC cases
        issue(1, 0, 0, JMP_ABS,  8'h00, 8'h05, 1);
        issue(1, 0, 0, JMP_NONE, 8'h00, 8'h00, 2);   // 5 -> 6
        issue(1, 0, 0, JMP_ABS,  8'h00, 8'h05, 1);
        issue(1, 0, 1, JMP_NONE, 8'hFD, 8'h00, 3);   // 5 - 3 -> 2
        issue(1, 0, 0, JMP_ABS,  8'h00, 8'h05, 1);
        issue(1, 0, 0, JMP_ABS,  8'h00, 8'h40, 1);   // -> 40
        issue(1, 0, 0, JMP_ABS,  8'h00, 8'hFF, 1);
        issue(1, 0, 0, JMP_NONE, 8'h00, 8'h00, 1);   // FF -> 00
        issue(1, 0, 0, JMP_ABS,  8'h00, 8'h02, 1);
        issue(1, 0, 1, JMP_NONE, 8'hFC, 8'h00, 1);   // 02 - 4 -> FE
        issue(1, 0, 1, 2'b11,    8'h01, 8'h33, 1);   // 11 is absolute
        issue(1, 0, 0, JMP_REL,  8'h10, 8'h99, 1);   // 33 + 16 -> 43
        wait_valid();

        // Ack never arrives: error after the last allowed FETCH cycle
        do_reset(0);
        repeat (TO) @(negedge clk);
        chk("to_err_early", 32'(FetchErr), 0);
        chk("to_req_last", 32'(mem_req), 1);
        @(negedge clk);
        chk("to_err", 32'(FetchErr), 1);
        chk("to_halted", 32'(Halted), 1);
        chk("to_req_off", 32'(mem_req), 0);
        repeat (3) @(negedge clk);
        chk("to_req_stays_off", 32'(mem_req), 0);

        // Ack in the final allowed cycle is accepted
        do_reset(TO);
        repeat (TO) @(negedge clk);
        chk("ack15_pending", 32'(InsValid), 0);
        @(negedge clk);
        chk("ack15_valid", 32'(InsValid), 1);
        chk("ack15_noerr", 32'(FetchErr), 0);

        // Randomized controller steps
        for (int n = 0; n < 60; n++) begin
            int l;
            l = ($urandom_range(0, 7) == 0) ? TO : int'($urandom_range(1, 4));
            issue(1, 0, 1'($urandom), 2'($urandom), 8'($urandom), PC_W'($urandom), l);
        end
        wait_valid();

        // Done with Buff_PC: PC commits, then frozen in HALT
        do_reset(1);
        issue(1, 0, 0, JMP_ABS,  8'h00, 8'h03, 1);
        issue(1, 1, 0, JMP_NONE, 8'h00, 8'h00, 1);
        for (int i = 0; i < 5; i++) begin
            Buff_PC = 1'b1; Jump = JMP_ABS; RegA = 8'h55;
            @(negedge clk);
            chk("halt_pc", 32'(PC), 4);
            chk("halt_noreq", 32'(mem_req), 0);
        end
        Buff_PC = 1'b0; Jump = JMP_NONE;

        // Reset in the middle of a fetch abandons it
        do_reset(1);
        issue(1, 0, 0, JMP_ABS, 8'h00, 8'h07, 0);
        @(negedge clk);
        Rst = 1'b0;
        @(negedge clk);
        chk("midrst_pc", 32'(PC), 0);
        chk("midrst_req", 32'(mem_req), 0);
        chk("midrst_valid", 32'(InsValid), 0);
        do_reset(2);
        wait_valid();
        @(negedge clk);

        chk("addr_q_empty", 32'(exp_addr_q.size()), 0);
        chk("ins_q_empty", 32'(exp_ins_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage directly upstream of the multicycle controller. Holds the program counter, fetches 16-bit instructions over a req/ack memory handshake, and presents the instruction register to the controller/decoder. Computes the next PC from the controller's branch/jump controls when the controller signals its last stage. Stops fetching on halt or on memory timeout.

## Interface
- PC_W, 8, program counter / instruction address width
- ACK_TIMEOUT, 15, max FETCH cycles waiting for mem_ack before error (≥1)

- clk  in  1  system clock, rising edge
- Rst  in  1  synchronous, active-low reset
- Buff_PC  in  1  controller last-stage strobe; commit next PC, start next fetch
- Branch  in  1  taken-branch qualifier, already PSW-resolved by controller
- Jump  in  2  jump select: bit1 = absolute from RegA, bit0 = PC-relative
- Done  in  1  controller halt request
- Imm  in  8  signed PC-relative offset
- RegA  in  PC_W  absolute jump target
- mem_req  out  1  instruction read request
- mem_addr  out  PC_W  instruction address (= PC)
- mem_ack  in  1  read data valid this cycle
- mem_rdata  in  16  instruction word
- Ins  out  16  instruction register (controller takes [15:8] and [1:0])
- InsValid  out  1  Ins holds a fetched instruction; controller may sequence
- PC  out  PC_W  current PC
- PCplus1  out  PC_W  PC+1 mod 2^PC_W (link/write-back source)
- Halted  out  1  sticky halt indicator
- FetchErr  out  1  sticky timeout error

## Operation
- States: IDLE, FETCH, EXEC, HALT.
- Reset (Rst=0 at edge): state=IDLE, PC=0, Ins=0, InsValid=0, Halted=0, FetchErr=0, timeout counter=0. mem_req=0, mem_addr=0, PCplus1=1.
- IDLE → FETCH unconditionally on first edge with Rst=1.
- FETCH: mem_req=1, mem_addr=PC. On mem_ack: Ins←mem_rdata, InsValid←1, → EXEC. Otherwise counter increments; if no ack in ACK_TIMEOUT consecutive FETCH cycles: FetchErr←1, Halted←1, → HALT.
- EXEC: mem_req=0. On Buff_PC: PC←next_pc, InsValid←0, → FETCH (counter cleared). On Done: Halted←1, → HALT. If both are asserted in the same cycle, PC is committed and the state goes to HALT.
- HALT: mem_req=0, all registers frozen. Exit only by reset.
- next_pc priority: Jump[1] → RegA; else Jump[0] or Branch → PC + sext(Imm); else PC+1. All arithmetic is modulo 2^PC_W and wraps silently (PC=2^PC_W−1 +1 → 0). Jump=11 is treated as absolute.
- Ignored inputs: Buff_PC/Done outside EXEC; mem_ack outside FETCH.
- Ins is unchanged except on an accepted ack.

## Timing
- mem_req rises the cycle after the first Rst=1 edge (IDLE takes one cycle).
- Ack in the same cycle mem_req rises is accepted. Ins/InsValid are valid the cycle after the ack edge. Minimum fetch latency is 1 cycle.
- Timeout: an ack in FETCH cycle k is accepted for k = 1..ACK_TIMEOUT. At the edge ending cycle ACK_TIMEOUT without an ack, FetchErr=1 from the next cycle.
- Buff_PC edge: the new PC is visible and mem_req=1 in the next cycle. InsValid=0 in that cycle.
- Reset mid-fetch: the request is abandoned, and mem_req=0 from the cycle after the reset edge.

## Structure
- Shared package: state encoding (IDLE/FETCH/EXEC/HALT), Jump encoding constants (JMP_NONE=00, JMP_REL=01, JMP_ABS=10), instruction width 16.
- One combinational sub-module: next_pc_calc (PC, Branch, Jump, Imm, RegA → next_pc, PCplus1).
- The timeout counter is $clog2(ACK_TIMEOUT+1) bits and lives in fetch_unit.

## Test plan
- Reset release, mem_ack tied high, mem_rdata=16'hA5C3 → mem_req high in cycle 1 with addr 0; Ins=A5C3 and InsValid=1 in cycle 2.
- EXEC with PC=5, Buff_PC, Jump=00, Branch=0 → next fetch addr 6. Repeat with Branch=1, Imm=−3 → addr 2. Repeat with Jump=10, RegA=8'h40 → addr 40.
- PC=8'hFF, Buff_PC with no jump → addr 00. PC=8'h02, Branch with Imm=−4 → addr FE.
- mem_ack withheld (ACK_TIMEOUT=15) → FetchErr=Halted=1 after cycle 15, mem_req=0. A separate run with the ack in cycle 15 → accepted, no error.
- Done and Buff_PC together in EXEC at PC=3 → PC=4, Halted=1, no further mem_req until reset.
- Rst=0 asserted mid-FETCH at PC=7 → next cycle PC=0, mem_req=0, InsValid=0. Refetch from 0 begins after release.
